// File: rtl/zmem_if.sv
// zmem_if: request/response bus between the core's bus initiator and zmem_responder
//   master: drives REQ_VALID/REQ_WRITE/REQ_ADDR/REQ_WDATA and RSP_READY
//   slave:  drives REQ_READY and RSP_VALID/RSP_RDATA/RSP_WRITE
interface zmem_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              REQ_VALID;
   logic              REQ_READY;
   logic              REQ_WRITE;
   logic [ADDR_W-1:0] REQ_ADDR;
   logic [DATA_W-1:0] REQ_WDATA;
   logic              RSP_VALID;
   logic              RSP_READY;
   logic [DATA_W-1:0] RSP_RDATA;
   logic              RSP_WRITE;
   modport master (
      output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RSP_READY,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_WRITE
   );
   modport slave (
      input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RSP_READY,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_WRITE
   );
endinterface

// File: rtl/zmem_responder.sv
// zmem_responder: 2^ADDR_W x DATA_W memory answering bus requests after WAIT_CYCLES wait states
//   CLK, RESET  clock and asynchronous active-high reset
//   bus         zmem_if slave: request channel in, response channel out
//   BUSY        high whenever not IDLE
//   ACCESS_CNT  completed response handshakes, wraps at 256
module zmem_responder #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   zmem_if.slave      bus,
   output logic       BUSY,
   output logic [7:0] ACCESS_CNT
);
   localparam int DEPTH = 1 << ADDR_W;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t            state, state_nxt;
   logic [3:0]        wait_cnt;
   logic [ADDR_W-1:0] addr_q, acc_addr;
   logic              write_q, acc_write, rwrite_q;
   logic [DATA_W-1:0] wdata_q, acc_wdata, rdata_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept, access, handshake;
   assign accept    = bus.REQ_VALID && state == IDLE;
   // zero wait states access on the accept edge itself, straight from the bus
   assign access    = WAIT_CYCLES == 0 ? accept : state == WAIT && wait_cnt == 4'd1;
   assign handshake = state == RESP && bus.RSP_READY;
   assign acc_addr  = state == IDLE ? bus.REQ_ADDR : addr_q;
   assign acc_write = state == IDLE ? bus.REQ_WRITE : write_q;
   assign acc_wdata = state == IDLE ? bus.REQ_WDATA : wdata_q;
   assign bus.REQ_READY = state == IDLE;
   assign bus.RSP_VALID = state == RESP;
   assign bus.RSP_RDATA = rdata_q;
   assign bus.RSP_WRITE = rwrite_q;
   assign BUSY          = state != IDLE;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;
         WAIT:    state_nxt = access ? RESP : WAIT;
         RESP:    state_nxt = handshake ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rwrite_q   <= 1'b0;
         ACCESS_CNT <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= bus.REQ_ADDR;
            write_q <= bus.REQ_WRITE;
            wdata_q <= bus.REQ_WDATA;
         end
         wait_cnt <= accept ? 4'(WAIT_CYCLES) : state == WAIT ? wait_cnt - 4'd1 : wait_cnt;
         if (access) begin
            if (acc_write) mem[acc_addr] <= acc_wdata;
            rdata_q  <= acc_write ? acc_wdata : mem[acc_addr];
            rwrite_q <= acc_write;
         end
         if (handshake) ACCESS_CNT <= ACCESS_CNT + 8'd1;
      end
endmodule

// File: tb/tb_zmem_responder.sv
// tb_zmem_responder: directed checks of zmem_responder built with WAIT_CYCLES 1 (slot 0), 0 (slot 1), 15 (slot 2)
module tb_zmem_responder;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [2:0] vld = '0;
   logic       wr = 1'b0;
   logic [3:0] ad = '0;
   logic [7:0] wd = '0;
   logic       rrdy = 1'b0;
   int         vectors = 0, miscompares = 0, cyc = 0;
   logic [2:0] busy, req_rdy, rsp_v, rsp_w;
   logic [7:0] cnt [3];
   logic [7:0] rsp_d [3];
   zmem_if #(.ADDR_W(4), .DATA_W(8)) zb [3] ();
   for (genvar g = 0; g < 3; g++) begin : g_bus
      assign zb[g].REQ_VALID = vld[g];
      assign zb[g].REQ_WRITE = wr;
      assign zb[g].REQ_ADDR  = ad;
      assign zb[g].REQ_WDATA = wd;
      assign zb[g].RSP_READY = (g == 0) ? rrdy : 1'b1;
      assign req_rdy[g]      = zb[g].REQ_READY;
      assign rsp_v[g]        = zb[g].RSP_VALID;
      assign rsp_w[g]        = zb[g].RSP_WRITE;
      assign rsp_d[g]        = zb[g].RSP_RDATA;
   end
   zmem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1))  dut1  (.CLK(CLK), .RESET(RESET), .bus(zb[0]), .BUSY(busy[0]), .ACCESS_CNT(cnt[0]));
   zmem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0))  dut0  (.CLK(CLK), .RESET(RESET), .bus(zb[1]), .BUSY(busy[1]), .ACCESS_CNT(cnt[1]));
   zmem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(15)) dut15 (.CLK(CLK), .RESET(RESET), .bus(zb[2]), .BUSY(busy[2]), .ACCESS_CNT(cnt[2]));
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   // Issue one request on slot s; returns at the first negedge showing RSP_VALID.
   // lat counts clock edges from the accept edge to that response cycle.
   task automatic xfer(input int s, input logic w, input logic [3:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic rw, output int lat);
      int n = 0;
      @(negedge CLK);
      wr = w; ad = a; wd = d; vld[s] = 1'b1;
      while (!req_rdy[s] && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) check("accept_timeout", 0, 1);
      @(negedge CLK);
      vld[s] = 1'b0;
      lat = 1;
      while (!rsp_v[s] && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      rd = rsp_d[s];
      rw = rsp_w[s];
   endtask
   // Hold a read request on slot s and measure the spacing between accept edges.
   task automatic thru(input int s, input int per);
      int t [3] = '{0, 0, 0};
      int k = 0;
      @(negedge CLK);
      wr = 1'b0; ad = 4'd2; vld[s] = 1'b1;
      for (int i = 0; i < 80 && k < 3; i++) begin
         if (req_rdy[s]) begin
            t[k] = cyc;
            k++;
         end
         @(negedge CLK);
      end
      vld[s] = 1'b0;
      check("period_1", t[1] - t[0], per);
      check("period_2", t[2] - t[1], per);
   endtask
   initial begin
      logic [7:0] rd;
      logic       rw;
      int         lat;
      @(negedge CLK);
      check("rst_req_ready", req_rdy[0], 1);
      check("rst_rsp_valid", rsp_v[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_cnt", cnt[0], 0);
      check("rst_rdata", rsp_d[0], 0);
      check("rst_rwrite", rsp_w[0], 0);
      RESET = 1'b0;
      rrdy = 1'b1;
      // read of never-written address 5
      xfer(0, 1'b0, 4'd5, 8'h00, rd, rw, lat);
      check("rd5_lat", lat, 2);
      check("rd5_data", rd, 8'h00);
      check("rd5_write", rw, 0);
      @(negedge CLK);
      check("rd5_cnt", cnt[0], 1);
      check("rd5_idle", busy[0], 0);
      // write then read back the same address
      xfer(0, 1'b1, 4'd3, 8'hA5, rd, rw, lat);
      check("wr3_echo", rd, 8'hA5);
      check("wr3_write", rw, 1);
      check("wr3_lat", lat, 2);
      xfer(0, 1'b0, 4'd3, 8'h00, rd, rw, lat);
      check("rd3_data", rd, 8'hA5);
      check("rd3_write", rw, 0);
      @(negedge CLK);
      check("rd3_cnt", cnt[0], 3);
      // response backpressure with a second request waiting
      rrdy = 1'b0;
      xfer(0, 1'b1, 4'd9, 8'h5A, rd, rw, lat);
      wr = 1'b0; ad = 4'd9; vld[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("bp_rsp_valid", rsp_v[0], 1);
         check("bp_rdata", rsp_d[0], 8'h5A);
         check("bp_req_ready", req_rdy[0], 0);
      end
      check("bp_cnt_held", cnt[0], 3);
      rrdy = 1'b1;
      @(negedge CLK);
      vld[0] = 1'b0;
      check("bp_released", req_rdy[0], 1);
      check("bp_cnt", cnt[0], 4);
      check("bp_rdata_kept", rsp_d[0], 8'h5A);
      xfer(0, 1'b0, 4'd9, 8'h00, rd, rw, lat);
      check("rd9_data", rd, 8'h5A);
      @(negedge CLK);
      // reset while a write of 0x3C to address 7 is in WAIT
      wr = 1'b1; ad = 4'd7; wd = 8'h3C; vld[0] = 1'b1;
      @(negedge CLK);
      vld[0] = 1'b0;
      check("wait_busy", busy[0], 1);
      RESET = 1'b1;
      #1;
      check("arst_busy", busy[0], 0);
      check("arst_cnt", cnt[0], 0);
      check("arst_rsp_valid", rsp_v[0], 0);
      @(negedge CLK);
      RESET = 1'b0;
      xfer(0, 1'b0, 4'd7, 8'h00, rd, rw, lat);
      check("rd7_after_rst", rd, 8'h00);
      xfer(0, 1'b0, 4'd3, 8'h00, rd, rw, lat);
      check("rd3_after_rst", rd, 8'h00);
      // counter wrap: 2 done, write + 253 reads makes 256 handshakes
      xfer(0, 1'b1, 4'd15, 8'hFF, rd, rw, lat);
      for (int i = 0; i < 252; i++) xfer(0, 1'b0, 4'd15, 8'h00, rd, rw, lat);
      @(negedge CLK);
      check("cnt_255", cnt[0], 255);
      xfer(0, 1'b0, 4'd15, 8'h00, rd, rw, lat);
      check("rd15_data", rd, 8'hFF);
      @(negedge CLK);
      check("cnt_wrap", cnt[0], 0);
      // zero wait states
      xfer(1, 1'b1, 4'd2, 8'h11, rd, rw, lat);
      check("w0_wr_lat", lat, 1);
      check("w0_wr_echo", rd, 8'h11);
      xfer(1, 1'b0, 4'd2, 8'h00, rd, rw, lat);
      check("w0_rd_lat", lat, 1);
      check("w0_rd_data", rd, 8'h11);
      thru(1, 2);
      // fifteen wait states
      xfer(2, 1'b1, 4'd4, 8'h77, rd, rw, lat);
      check("w15_wr_lat", lat, 16);
      xfer(2, 1'b0, 4'd4, 8'h00, rd, rw, lat);
      check("w15_rd_lat", lat, 16);
      check("w15_rd_data", rd, 8'h77);
      thru(2, 17);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
